// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID pipeline sequencer (package mips_pkg).
// Holds the PC mux encoding, MDU op classes, FSM states and the load-use hazard helper.
package mips_pkg;

  localparam int MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_EXC    = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    MDU_NONE = 2'd0,
    MDU_MULT = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_MFHL = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_EXC_FLUSH    = 2'd1,
    ST_EXC_REDIRECT = 2'd2
  } pipe_state_e;

  // Register 0 is hardwired to zero, so a load targeting it can never create a hazard.
  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipe_ctrl_mdu_timer.sv
// Multiply/divide busy timer: loads a cycle count, decrements to zero and saturates there.
// busy is high whenever the count is non-zero.
module mdu_timer
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [MDU_CNT_W-1:0] load_val,
  output logic                 busy
);

  logic [MDU_CNT_W-1:0] cnt_q;
  logic [MDU_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// IF/ID pipeline sequencer: load-use and MDU stalls, branch flushes, two-cycle exception entry.
// Optional macro PIPE_CTRL_STALL_CNT_EN adds a 32-bit stall_cycles counter output.
module pipe_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 12,
  parameter int DIV_CYCLES  = 35
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [1:0]  id_mdu_op,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        except,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  pc_sel,
`ifdef PIPE_CTRL_STALL_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        epc_we,
  output logic        mdu_busy
);

  localparam logic [MDU_CNT_W-1:0] MULT_LOAD = MDU_CNT_W'(MULT_CYCLES - 1);
  localparam logic [MDU_CNT_W-1:0] DIV_LOAD  = MDU_CNT_W'(DIV_CYCLES - 1);

  pipe_state_e          state_q;
  pipe_state_e          state_d;
  pc_sel_e              pc_sel_d;
  mdu_op_e              id_op;
  logic                 load_use;
  logic                 mdu_hazard;
  logic                 timer_busy;
  logic                 mdu_load;
  logic [MDU_CNT_W-1:0] mdu_load_val;

  assign id_op      = mdu_op_e'(id_mdu_op);
  assign load_use   = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
  assign mdu_hazard = timer_busy && (id_op != MDU_NONE);

  always_comb begin
    state_d      = state_q;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    pc_sel_d     = PC_SEQ;
    epc_we       = 1'b0;
    mdu_load     = 1'b0;
    mdu_load_val = '0;
    if (!rst_n) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      state_d    = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (except) begin
            epc_we     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            pc_we      = 1'b0;
            state_d    = ST_EXC_FLUSH;
          end else if (ex_branch_taken) begin
            pc_sel_d   = PC_BRANCH;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use || mdu_hazard) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end else if (id_op == MDU_MULT) begin
            mdu_load     = 1'b1;
            mdu_load_val = MULT_LOAD;
          end else if (id_op == MDU_DIV) begin
            mdu_load     = 1'b1;
            mdu_load_val = DIV_LOAD;
          end
        end
        // Exception and branch requests arriving during entry are dropped.
        ST_EXC_FLUSH: begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = ST_EXC_REDIRECT;
        end
        ST_EXC_REDIRECT: begin
          pc_sel_d   = PC_EXC;
          ifid_flush = 1'b1;
          state_d    = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  mdu_timer u_mdu_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mdu_load),
    .load_val (mdu_load_val),
    .busy     (timer_busy)
  );

  assign pc_sel   = pc_sel_d;
  assign mdu_busy = rst_n && timer_busy;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_we) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stalls, branches, exception entry, MDU and reset.
// Inputs change on the falling edge; Mealy outputs are sampled 1 ns later.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic [1:0]  id_mdu_op;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        except;
  logic        pc_we;
  logic        ifid_we;
  logic        ifid_flush;
  logic        idex_flush;
  logic [1:0]  pc_sel;
  logic        epc_we;
  logic        mdu_busy;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.MULT_CYCLES(12), .DIV_CYCLES(35)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_mdu_op       (id_mdu_op),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .except          (except),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pc_sel          (pc_sel),
`ifdef PIPE_CTRL_STALL_CNT_EN
    .stall_cycles    (stall_cycles),
`endif
    .epc_we          (epc_we),
    .mdu_busy        (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Packs {pc_we, ifid_we, ifid_flush, idex_flush, pc_sel[1:0], epc_we} for one-line comparisons.
  function automatic logic [31:0] ctl();
    return {25'd0, pc_we, ifid_we, ifid_flush, idex_flush, pc_sel, epc_we};
  endfunction

  function automatic logic [31:0] mk(input logic pw, input logic iw, input logic ifl,
                                     input logic idf, input logic [1:0] sel, input logic ew);
    return {25'd0, pw, iw, ifl, idf, sel, ew};
  endfunction

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_mdu_op = 2'd0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0; except = 1'b0;
  endtask

  // Advance to the next falling edge; caller then sets inputs and calls settle.
  task automatic next_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int stalls;
    rst_n = 1'b0;
    idle_inputs();

    // Reset: outputs forced while rst_n is low.
    next_cycle(); settle();
    check("reset_ctl", ctl(), mk(0, 0, 1, 1, 2'd0, 0));
    check("reset_busy", {31'd0, mdu_busy}, 32'd0);
    next_cycle(); rst_n = 1'b1; settle();
    check("run_idle", ctl(), mk(1, 1, 0, 0, 2'd0, 0));

    // Load-use via rs.
    next_cycle(); ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; settle();
    check("lu_rs_stall", ctl(), mk(0, 0, 0, 1, 2'd0, 0));
    next_cycle(); settle();
    check("lu_rs_release", ctl(), mk(1, 1, 0, 0, 2'd0, 0));
    // r0 destination never stalls.
    next_cycle(); ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; settle();
    check("lu_r0_nostall", ctl(), mk(1, 1, 0, 0, 2'd0, 0));
    // Load-use via rt only when ID reads rt.
    next_cycle(); ex_mem_read = 1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1; settle();
    check("lu_rt_stall", ctl(), mk(0, 0, 0, 1, 2'd0, 0));
    next_cycle(); ex_mem_read = 1; ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 0; settle();
    check("lu_rt_unused", ctl(), mk(1, 1, 0, 0, 2'd0, 0));

    // MDU: mult then mfhi -> 11 stall cycles.
    next_cycle(); id_mdu_op = 2'd1; settle();
    check("mult_start", ctl(), mk(1, 1, 0, 0, 2'd0, 0));
    check("mult_start_busy", {31'd0, mdu_busy}, 32'd0);
    stalls = 0;
    next_cycle(); id_mdu_op = 2'd3; settle();
    check("mfhi_busy", {31'd0, mdu_busy}, 32'd1);
    while (!pc_we && stalls < 50) begin
      stalls++;
      next_cycle(); id_mdu_op = 2'd3; settle();
    end
    check("mdu_stall_len", stalls, 32'd11);
    check("mdu_release_busy", {31'd0, mdu_busy}, 32'd0);
    check("mdu_release_ctl", ctl(), mk(1, 1, 0, 0, 2'd0, 0));

    // Branch with coincident load-use and mult: branch wins, mult not started.
    next_cycle(); ex_branch_taken = 1; ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; id_mdu_op = 2'd1; settle();
    check("branch_lu", ctl(), mk(1, 1, 1, 1, 2'd1, 0));
    next_cycle(); settle();
    check("branch_no_mult", {31'd0, mdu_busy}, 32'd0);

    // Mult in flight, then exception entry.
    next_cycle(); id_mdu_op = 2'd1; settle();
    next_cycle(); except = 1; settle();
    check("exc_t0", ctl(), mk(0, 1, 1, 1, 2'd0, 1));
    next_cycle(); ex_branch_taken = 1; settle();
    check("exc_t1_branch_ignored", ctl(), mk(0, 1, 1, 1, 2'd0, 0));
    next_cycle(); except = 1; settle();
    check("exc_t2", {31'd0, pc_we}, 32'd1);
    check("exc_t2_sel", {30'd0, pc_sel}, 32'd2);
    check("exc_t2_epc", {31'd0, epc_we}, 32'd0);
    next_cycle(); settle();
    check("exc_t3_run", ctl(), mk(1, 1, 0, 0, 2'd0, 0));
    check("exc_mdu_continues", {31'd0, mdu_busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      next_cycle(); settle();
    end
    check("mdu_drained", {31'd0, mdu_busy}, 32'd0);

    // Div, then reset when the count reaches 20.
    next_cycle(); id_mdu_op = 2'd2; settle();
    for (int i = 0; i < 14; i++) begin
      next_cycle(); settle();
    end
    check("div_busy_at_20", {31'd0, mdu_busy}, 32'd1);
    next_cycle(); rst_n = 1'b0; settle();
    check("div_reset_ctl", ctl(), mk(0, 0, 1, 1, 2'd0, 0));
    check("div_reset_busy", {31'd0, mdu_busy}, 32'd0);
    next_cycle(); rst_n = 1'b1; id_mdu_op = 2'd3; settle();
    check("after_reset_busy", {31'd0, mdu_busy}, 32'd0);
    check("after_reset_ctl", ctl(), mk(1, 1, 0, 0, 2'd0, 0));

    // Reset mid-exception aborts entry.
    next_cycle(); except = 1; settle();
    next_cycle(); rst_n = 1'b0; settle();
    next_cycle(); rst_n = 1'b1; settle();
    check("exc_abort_run", ctl(), mk(1, 1, 0, 0, 2'd0, 0));

    // One load-use stall plus one exception: 3 cycles with pc_we low.
    next_cycle(); ex_mem_read = 1; ex_rt = 5'd9; id_rs = 5'd9; settle();
    next_cycle(); except = 1; settle();
    next_cycle(); settle();
    next_cycle(); settle();
    next_cycle(); settle();
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("stall_cycles", stall_cycles, 32'd3);
`endif
    check("final_run", ctl(), mk(1, 1, 0, 0, 2'd0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
